// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment scan driver.
package seg7_pkg;

    typedef logic [6:0] seg_t;   // {a,b,c,d,e,f,g}

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    localparam seg_t SEG_OFF = 7'b0000000;

    localparam seg_t SEG_DIGIT [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Control and display bus of the scan driver; state is exported for debug visibility.
interface seg7_scan_driver_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    // No valid/ready pair here: load is a single-cycle strobe that is always
    // accepted, en/lz_blank are levels sampled every clock.
    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    lz_blank;
    seg_t                    seg;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_start;
    logic [1:0]              state;

    modport master (
        output en, load, bcd_in, lz_blank,
        input  seg, dig_sel, frame_start, state
    );

    modport slave (
        input  en, load, bcd_in, lz_blank,
        output seg, dig_sel, frame_start, state
    );

endinterface

// File: rtl/seg7_digit_decode.sv
// BCD nibble to 7-segment pattern; values 10..15 light nothing.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output seg_t       seg
);

    always_comb begin
        case (value)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner: SHOW one digit, GAP dark, next digit.
// Outputs are registered from the next-state values so they align with the state.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GAP_CYCLES  = 2
)(
    input logic            clk,
    input logic            rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int MAXC = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int DW   = 4 * NUM_DIGITS;

    localparam logic [1:0] ST_OFF  = OFF;
    localparam logic [1:0] ST_SHOW = SHOW;
    localparam logic [1:0] ST_GAP  = GAP;

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         shadow_q;
    logic [DW-1:0]         frame_q, frame_d;
    seg_t                  seg_q, seg_dec;
    logic [NUM_DIGITS-1:0] dig_sel_q;
    logic                  fs_q;

    logic                  all_zero;
    logic [NUM_DIGITS-1:0] blank_d;
    logic [3:0]            nib_d;
    logic                  blk_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        frame_d = frame_q;
        if (!bus.en) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_SHOW: begin
                    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        // Frame is refreshed only when wrapping back to digit 0.
                        if (idx_q == IW'(NUM_DIGITS - 1)) begin
                            idx_d   = '0;
                            frame_d = shadow_q;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                    frame_d = shadow_q;
                end
            endcase
        end
    end

    // A digit above 0 is blanked when it and every digit above it are zero.
    always_comb begin
        all_zero = 1'b1;
        blank_d  = '0;
        nib_d    = frame_d[3:0];
        blk_d    = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero & (frame_d[4*i +: 4] == 4'd0);
            blank_d[i] = bus.lz_blank & all_zero;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                nib_d = frame_d[4*i +: 4];
                blk_d = blank_d[i];
            end
        end
    end

    seg7_digit_decode u_dec (
        .value (nib_d),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            frame_q   <= '0;
            seg_q     <= SEG_OFF;
            dig_sel_q <= '0;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            if (bus.load) shadow_q <= bus.bcd_in;
            seg_q     <= (state_d == ST_SHOW && !blk_d) ? seg_dec : SEG_OFF;
            dig_sel_q <= (state_d == ST_SHOW) ? (NUM_DIGITS'(1) << idx_d) : '0;
            fs_q      <= (state_d == ST_SHOW) && (idx_d == '0) && (cnt_d == '0);
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dig_sel     = dig_sel_q;
    assign bus.frame_start = fs_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4 lit cycles, 1 gap cycle.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GC = 1;
    localparam int W  = ND + 7 + 1;

    logic clk;
    logic rst_n;
    int   assert_cnt;
    int   fail_cnt;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GAP_CYCLES  (GC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic wait_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [15:0] value, input logic lz);
        bus.en       = 1'b0;
        bus.lz_blank = lz;
        bus.load     = 1'b1;
        bus.bcd_in   = value;
        wait_pos();
        bus.load = 1'b0;
        bus.en   = 1'b1;
        wait_pos();
    endtask

    task automatic push_digit(input logic [ND-1:0] sel, input seg_t s, input logic fs);
        for (int c = 0; c < RD; c++) exp_q.push_back({sel, s, fs && (c == 0)});
        for (int c = 0; c < GC; c++) exp_q.push_back('0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        assert_cnt++;
        if (bus.seg !== 7'b0) begin fail_cnt++; $display("FAIL reset_seg: got %b expected %b", bus.seg, 7'b0); end
        assert_cnt++;
        if (bus.dig_sel !== 4'b0) begin fail_cnt++; $display("FAIL reset_dig_sel: got %b expected %b", bus.dig_sel, 4'b0); end
        assert_cnt++;
        if (bus.frame_start !== 1'b0) begin fail_cnt++; $display("FAIL reset_fs: got %b expected 0", bus.frame_start); end
        assert_cnt++;
        if (bus.state !== 2'd0) begin fail_cnt++; $display("FAIL reset_state: got %0d expected 0", bus.state); end

        wait_pos();
        rst_n = 1'b1;
        wait_pos();
        bus.load   = 1'b1;
        bus.bcd_in = 16'h1234;
        wait_pos();
        bus.load = 1'b0;
        bus.en   = 1'b1;
        repeat (12) wait_pos();
        assert_cnt++;
        if (bus.dig_sel !== 4'b0100) begin fail_cnt++; $display("FAIL pre_reset_digit2: got %b expected %b", bus.dig_sel, 4'b0100); end
        rst_n = 1'b0;
        #1;
        assert_cnt++;
        if ({bus.dig_sel, bus.seg, bus.frame_start} !== 12'b0) begin
            fail_cnt++;
            $display("FAIL async_reset: got sel=%b seg=%b fs=%b expected all zero", bus.dig_sel, bus.seg, bus.frame_start);
        end
        #2;
        rst_n = 1'b1;
        wait_pos();
        @(negedge clk);
        assert_cnt++;
        if ({bus.dig_sel, bus.seg, bus.frame_start} !== {4'b0001, 7'b1111110, 1'b1}) begin
            fail_cnt++;
            $display("FAIL after_reset_digit0: got sel=%b seg=%b fs=%b expected sel=0001 seg=1111110 fs=1",
                     bus.dig_sel, bus.seg, bus.frame_start);
        end
    endtask

    task automatic test_scan();
        int n;
        exp_q.delete();
        restart(16'h1234, 1'b0);
        for (int f = 0; f < 2; f++) begin
            push_digit(4'b0001, 7'b0110011, 1'b1);
            push_digit(4'b0010, 7'b1111001, 1'b0);
            push_digit(4'b0100, 7'b1101101, 1'b0);
            push_digit(4'b1000, 7'b0110000, 1'b0);
        end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs_v = {bus.dig_sel, bus.seg, bus.frame_start};
            assert_cnt++;
            if (obs_v !== exp_v) begin
                fail_cnt++;
                $display("FAIL scan cyc %0d: got sel=%b seg=%b fs=%b expected sel=%b seg=%b fs=%b",
                         i, obs_v[11:8], obs_v[7:1], obs_v[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_lz_blank();
        int n;
        exp_q.delete();
        restart(16'h0070, 1'b1);
        push_digit(4'b0001, 7'b1111110, 1'b1);
        push_digit(4'b0010, 7'b1110000, 1'b0);
        push_digit(4'b0100, 7'b0000000, 1'b0);
        push_digit(4'b1000, 7'b0000000, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs_v = {bus.dig_sel, bus.seg, bus.frame_start};
            assert_cnt++;
            if (obs_v !== exp_v) begin
                fail_cnt++;
                $display("FAIL lz_0070 cyc %0d: got sel=%b seg=%b fs=%b expected sel=%b seg=%b fs=%b",
                         i, obs_v[11:8], obs_v[7:1], obs_v[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
        end

        exp_q.delete();
        restart(16'h0000, 1'b1);
        push_digit(4'b0001, 7'b1111110, 1'b1);
        push_digit(4'b0010, 7'b0000000, 1'b0);
        push_digit(4'b0100, 7'b0000000, 1'b0);
        push_digit(4'b1000, 7'b0000000, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs_v = {bus.dig_sel, bus.seg, bus.frame_start};
            assert_cnt++;
            if (obs_v !== exp_v) begin
                fail_cnt++;
                $display("FAIL lz_0000 cyc %0d: got sel=%b seg=%b fs=%b expected sel=%b seg=%b fs=%b",
                         i, obs_v[11:8], obs_v[7:1], obs_v[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_frame_coherency();
        int n;
        exp_q.delete();
        restart(16'h1234, 1'b0);
        push_digit(4'b0001, 7'b0110011, 1'b1);
        push_digit(4'b0010, 7'b1111001, 1'b0);
        push_digit(4'b0100, 7'b1101101, 1'b0);
        push_digit(4'b1000, 7'b0110000, 1'b0);
        push_digit(4'b0001, 7'b1111111, 1'b1);
        push_digit(4'b0010, 7'b1110000, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs_v = {bus.dig_sel, bus.seg, bus.frame_start};
            assert_cnt++;
            if (obs_v !== exp_v) begin
                fail_cnt++;
                $display("FAIL coherency cyc %0d: got sel=%b seg=%b fs=%b expected sel=%b seg=%b fs=%b",
                         i, obs_v[11:8], obs_v[7:1], obs_v[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
            if (i == 11) begin
                bus.load   = 1'b1;
                bus.bcd_in = 16'h5678;
            end
            if (i == 12) bus.load = 1'b0;
        end
    endtask

    task automatic test_invalid_nibble();
        int n;
        exp_q.delete();
        restart(16'h00A0, 1'b0);
        push_digit(4'b0001, 7'b1111110, 1'b1);
        push_digit(4'b0010, 7'b0000000, 1'b0);
        push_digit(4'b0100, 7'b1111110, 1'b0);
        push_digit(4'b1000, 7'b1111110, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs_v = {bus.dig_sel, bus.seg, bus.frame_start};
            assert_cnt++;
            if (obs_v !== exp_v) begin
                fail_cnt++;
                $display("FAIL invalid_nibble cyc %0d: got sel=%b seg=%b fs=%b expected sel=%b seg=%b fs=%b",
                         i, obs_v[11:8], obs_v[7:1], obs_v[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_en_drop();
        int n;
        exp_q.delete();
        restart(16'h1234, 1'b0);
        push_digit(4'b0001, 7'b0110011, 1'b1);
        push_digit(4'b0010, 7'b1111001, 1'b0);
        for (int c = 0; c < 5; c++) exp_q.push_back('0);
        push_digit(4'b0001, 7'b0110011, 1'b1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs_v = {bus.dig_sel, bus.seg, bus.frame_start};
            assert_cnt++;
            if (obs_v !== exp_v) begin
                fail_cnt++;
                $display("FAIL en_drop cyc %0d: got sel=%b seg=%b fs=%b expected sel=%b seg=%b fs=%b",
                         i, obs_v[11:8], obs_v[7:1], obs_v[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
            if (i == 10) begin
                assert_cnt++;
                if (bus.state !== 2'd0) begin fail_cnt++; $display("FAIL en_drop_state: got %0d expected 0", bus.state); end
            end
            if (i == 9)  bus.en = 1'b0;
            if (i == 14) bus.en = 1'b1;
        end
    endtask

    initial begin
        assert_cnt   = 0;
        fail_cnt     = 0;
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.bcd_in   = '0;
        bus.lz_blank = 1'b0;

        test_reset();
        test_scan();
        test_lz_blank();
        test_frame_coherency();
        test_invalid_nibble();
        test_en_drop();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
